// File: rtl/edge_detect_delayed.sv
// edge_detect_delayed
// Multi-channel edge detector with a fixed-latency pulse delay line.
// Each channel is edge-detected (rise, fall or both, chosen by mode_i) and
// every detected edge produces a one-cycle pulse on y_o exactly DELAY cycles
// later. any_o is the OR of y_o, aligned with it.
// Optional feature macro: EDGE_DET_CNT_EN builds a saturating event counter
// (count_o) with synchronous clear (clr_i). Without it count_o is tied to 0
// and clr_i is ignored.
// Reset is synchronous and active-high.
// There is no handshake: x_i is sampled every cycle, and y_o/any_o/count_o
// are valid every cycle after the first reset edge.

module edge_detect_delayed #(
    parameter int WIDTH = 4,
    parameter int DELAY = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] y_o,
    output logic             any_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] x_q;
    logic             prime_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] stage_q [DELAY];

    // Input history; prime_q blocks detection on the first post-reset sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            prime_q <= 1'b0;
        end else begin
            x_q     <= x_i;
            prime_q <= 1'b1;
        end
    end

    // Edge detection; mode is applied here only, never to queued pulses.
    always_comb begin
        rise = x_i & ~x_q;
        fall = ~x_i & x_q;
        det  = {WIDTH{prime_q}} &
               (({WIDTH{mode_i[0]}} & rise) | ({WIDTH{mode_i[1]}} & fall));
    end

    // DELAY-stage shift register; events are carried one per stage, never merged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DELAY; s++) stage_q[s] <= '0;
        end else begin
            stage_q[0] <= det;
            for (int s = 1; s < DELAY; s++) stage_q[s] <= stage_q[s-1];
        end
    end

    assign y_o = stage_q[DELAY-1];

    generate
        if (DELAY == 1) begin : g_any_comb
            assign any_o = |stage_q[0];
        end else begin : g_any_reg
            logic any_q;
            // Registered OR taken one stage early so it lines up with y_o.
            always_ff @(posedge clk) begin
                if (rst) any_q <= 1'b0;
                else     any_q <= |stage_q[DELAY-2];
            end
            assign any_o = any_q;
        end
    endgenerate

`ifdef EDGE_DET_CNT_EN
    localparam int PW = $clog2(WIDTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] SAT = (SW'(1) << CNT_W) - SW'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;

    // Popcount of the output pulses and the widened (non-wrapping) sum.
    always_comb begin
        pop = '0;
        for (int k = 0; k < WIDTH; k++) pop = pop + PW'(y_o[k]);
        sum = SW'(cnt_q) + SW'(pop);
    end

    // Saturating event counter; clear wins over same-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst || clr_i)  cnt_q <= '0;
        else if (sum > SAT) cnt_q <= SAT[CNT_W-1:0];
        else                cnt_q <= sum[CNT_W-1:0];
    end

    assign count_o = cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign count_o    = '0;
`endif

endmodule

// File: tb/tb_edge_detect_delayed.sv
// Bench for edge_detect_delayed (WIDTH=4, DELAY=2, CNT_W=3).
// The driver issues directed vectors one per cycle and pushes the expected
// {y_o, any_o, count_o} for that cycle into exp_q; a monitor pops and
// compares at every falling edge. Scenario-level expectations (pulse totals,
// final counts, the clear cycle) are hand-computed constants.

module tb_edge_detect_delayed;

    localparam int WIDTH = 4;
    localparam int DELAY = 2;
    localparam int CNT_W = 3;
    localparam int W     = WIDTH + 1 + CNT_W;
`ifdef EDGE_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] x_i = '0;
    logic [1:0]       mode_i = 2'b00;
    logic             clr_i = 1'b0;
    logic [WIDTH-1:0] y_o;
    logic             any_o;
    logic [CNT_W-1:0] count_o;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_total = 0;

    // Reference state
    logic [WIDTH-1:0] m_xp = '0;
    bit               m_prime = 1'b0;
    logic [WIDTH-1:0] m_pipe [DELAY];
    int               m_cnt = 0;
    bit               m_known = 1'b0;

    edge_detect_delayed #(.WIDTH(WIDTH), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .x_i     (x_i),
        .mode_i  (mode_i),
        .clr_i   (clr_i),
        .y_o     (y_o),
        .any_o   (any_o),
        .count_o (count_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the reference by one clock edge.
    task automatic step(input logic [WIDTH-1:0] x, input logic [1:0] mode,
                        input logic clr, input logic r);
        logic [WIDTH-1:0] det;
        @(posedge clk);
        #1;
        x_i = x; mode_i = mode; clr_i = clr; rst = r;
        if (m_known)
            exp_q.push_back({m_pipe[DELAY-1], |m_pipe[DELAY-1], CNT_W'(m_cnt)});
        if (r) begin
            for (int s = 0; s < DELAY; s++) m_pipe[s] = '0;
            m_xp = '0; m_prime = 1'b0; m_cnt = 0; m_known = 1'b1;
        end else begin
            det = '0;
            for (int k = 0; k < WIDTH; k++) begin
                if (m_prime && mode[0] && x[k] && !m_xp[k]) det[k] = 1'b1;
                if (m_prime && mode[1] && !x[k] && m_xp[k]) det[k] = 1'b1;
            end
            if (CNT_EN) begin
                if (clr) m_cnt = 0;
                else
                    for (int k = 0; k < WIDTH; k++)
                        if (m_pipe[DELAY-1][k] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            for (int s = DELAY - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = det;
            m_xp = x; m_prime = 1'b1;
        end
    endtask

    task automatic do_reset(input logic [WIDTH-1:0] x, input logic [1:0] mode);
        step(x, mode, 1'b0, 1'b1);
        step(x, mode, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic [WIDTH-1:0] x, input logic [1:0] mode);
        repeat (n) step(x, mode, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pop and compare one expected entry per cycle
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < WIDTH; k++) if (y_o[k] === 1'b1) pulse_total++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (y_o !== e[W-1 -: WIDTH]) begin
                    n_fail++;
                    $display("FAIL y_o @%0t: got %b, expected %b", $time, y_o, e[W-1 -: WIDTH]);
                end
                n_cmp++;
                if (any_o !== e[CNT_W]) begin
                    n_fail++;
                    $display("FAIL any_o @%0t: got %b, expected %b", $time, any_o, e[CNT_W]);
                end
                n_cmp++;
                if (count_o !== e[CNT_W-1:0]) begin
                    n_fail++;
                    $display("FAIL count_o @%0t: got %0d, expected %0d", $time, count_o, e[CNT_W-1:0]);
                end
            end
        end
    end

    // Directed scenarios
    initial begin
        int p0;
        int guard;

        // Falling edges only: one pulse from the fall, none from the rise
        do_reset(4'b0000, 2'b10);
        settle();
        check("reset_y", int'(y_o), 0);
        check("reset_count", int'(count_o), 0);
        p0 = pulse_total;
        idle(4, 4'b0001, 2'b10);
        idle(6, 4'b0000, 2'b10);
        settle();
        check("fall_pulses", pulse_total - p0, 1);
        check("fall_count", int'(count_o), CNT_EN ? 1 : 0);

        // Both edges: six back-to-back pulses on channel 2
        do_reset(4'b0000, 2'b11);
        idle(2, 4'b0000, 2'b11);
        p0 = pulse_total;
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'b0100 : 4'b0000, 2'b11, 1'b0, 1'b0);
        idle(5, 4'b0000, 2'b11);
        settle();
        check("both_pulses", pulse_total - p0, 6);
        check("both_count", int'(count_o), CNT_EN ? 6 : 0);

        // High inputs through reset never report an edge
        do_reset(4'b1111, 2'b01);
        p0 = pulse_total;
        idle(8, 4'b1111, 2'b01);
        settle();
        check("postrst_pulses", pulse_total - p0, 0);
        check("postrst_count", int'(count_o), 0);

        // Mode change while a pulse is queued
        do_reset(4'b0000, 2'b01);
        idle(2, 4'b0000, 2'b01);
        p0 = pulse_total;
        step(4'b0001, 2'b01, 1'b0, 1'b0);
        step(4'b0001, 2'b00, 1'b0, 1'b0);
        step(4'b0000, 2'b00, 1'b0, 1'b0);
        step(4'b0001, 2'b00, 1'b0, 1'b0);
        idle(5, 4'b0001, 2'b00);
        settle();
        check("mode_pulses", pulse_total - p0, 1);
        check("mode_count", int'(count_o), CNT_EN ? 1 : 0);

        // Saturation after ten edges, then a clear coinciding with a pulse
        do_reset(4'b0000, 2'b11);
        idle(2, 4'b0000, 2'b11);
        p0 = pulse_total;
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 4'b0001 : 4'b0000, 2'b11, 1'b0, 1'b0);
        idle(4, 4'b0000, 2'b11);
        settle();
        check("sat_count", int'(count_o), CNT_EN ? 7 : 0);
        step(4'b0001, 2'b11, 1'b0, 1'b0);
        step(4'b0001, 2'b11, 1'b0, 1'b0);
        step(4'b0001, 2'b11, 1'b1, 1'b0);
        settle();
        check("clr_pulse_y", int'(y_o), 1);
        step(4'b0001, 2'b11, 1'b0, 1'b0);
        settle();
        check("clr_count", int'(count_o), 0);
        idle(3, 4'b0001, 2'b11);
        settle();
        check("sat_pulses", pulse_total - p0, 11);

        // Reset in the cycle after a detection drops the pulse
        do_reset(4'b0000, 2'b01);
        idle(2, 4'b0000, 2'b01);
        p0 = pulse_total;
        step(4'b0001, 2'b01, 1'b0, 1'b0);
        step(4'b0001, 2'b01, 1'b0, 1'b1);
        idle(6, 4'b0000, 2'b01);
        settle();
        check("midrst_pulses", pulse_total - p0, 0);
        check("midrst_count", int'(count_o), 0);

        // Drain the scoreboard within a bounded number of cycles
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("drain_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_detect_delayed.md
# edge_detect_delayed

Parametrised, multi-channel successor to the single-bit falling-edge delayer. Each of `WIDTH` input channels is edge-detected (rise, fall, or both, selected at run time). Every detected edge emits a one-cycle pulse exactly `DELAY` clock cycles later. The block sits between raw level inputs (buttons, handshake lines, status bits) and logic that needs time-aligned single-cycle event strobes. An optional saturating event counter is available.

## Interface
- `WIDTH`, default 4: number of independent channels, ≥1.
- `DELAY`, default 2: pipeline stages between detection and output pulse, ≥1.
- `CNT_W`, default 8: event counter width, ≥1.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `x_i`, input, WIDTH: level inputs, one bit per channel.
- `mode_i`, input, 2: edge select.
  - 00: none.
  - 01: rising.
  - 10: falling.
  - 11: both.
- `clr_i`, input, 1: synchronous clear of the event counter.
- `y_o`, output, WIDTH: per-channel one-cycle edge pulses, delayed by `DELAY`.
- `any_o`, output, 1: OR of all bits of `y_o`.
- `count_o`, output, CNT_W: saturating event count; tied to 0 when the counter is compiled out.

## Operation
- Input history:
  - `x_q` register captures `x_i` every cycle.
  - `prime_q` flag is 0 after reset and set to 1 on the first non-reset cycle.
- Detection, combinational, per channel k:
  - `rise[k] = x_i[k] & ~x_q[k]`
  - `fall[k] = ~x_i[k] & x_q[k]`
  - `det[k] = prime_q & ((mode_i[0] & rise[k]) | (mode_i[1] & fall[k]))`
- Delay line:
  - `det` enters a `DELAY`-stage shift register, WIDTH bits per stage.
  - `y_o` is the last stage.
  - The line does not collapse or merge events. Back-to-back edges on one channel (an x_i toggle every cycle in mode 11) yield back-to-back output pulses.
- Mode is applied at detection time only. Changing `mode_i` never alters pulses already in the delay line.
- `any_o` is a registered OR, computed from the penultimate stage so that it aligns with `y_o`. When `DELAY`=1, `any_o` is the combinational OR of `y_o`.
- Counter:
  - Each cycle, `count_o` adds popcount(`y_o`).
  - It saturates at 2^CNT_W−1 and never wraps.
  - `clr_i` forces 0 on the next edge. When `clr_i` and pulses coincide, clear wins and that cycle's pulses are not counted.
- Reset: `x_q`, `prime_q`, all delay stages and the counter go to 0 in the same edge.
  - Pending pulses are discarded.
  - No edge is reported from the first post-reset sample, whatever the level of `x_i`.

## Timing
- Reset values: `y_o`=0, `any_o`=0, `count_o`=0.
- Latency: x_i changes after clock edge N−1 and is sampled at edge N, so det is high in the cycle ending at edge N. `y_o` is high for exactly one cycle, starting after edge N+DELAY−1.
  - DELAY=2: the pulse is visible two cycles after the input transition.
- Width: one pulse per edge; each pulse lasts exactly one cycle and is never stretched.
- Counter: `count_o` updates one cycle after the corresponding `y_o` pulse.
- Reset asserted mid-flight: all in-flight pulses are lost. The first possible detection is on the second sample after `rst` deasserts.
- Simultaneous edges on several channels: independent pulses in the same cycle. The counter adds all of them in that cycle.

## Configuration
- `EDGE_DET_CNT_EN` defined: the saturating counter and `clr_i` handling are built.
- `EDGE_DET_CNT_EN` undefined:
  - No counter registers are built.
  - `count_o` is tied to 0.
  - `clr_i` is ignored.
  - `y_o` and `any_o` behaviour is identical to the defined case.

## Test plan
- **Falling, WIDTH=4, DELAY=2, mode=10.** Hold x_i=0000 through reset, then 0001 for 4 cycles, then 0000.
  - Required: a single pulse y_o=0001 two cycles after the falling transition.
  - Required: no pulse on the rise.
  - Required: count_o=1.
- **Both edges, mode=11.** Toggle x_i[2] every cycle for 6 cycles.
  - Required: y_o[2] high for 6 consecutive cycles, delayed by 2.
  - Required: any_o matches y_o[2].
  - Required: count_o=6.
- **Post-reset safety.** Hold x_i=1111 during and after reset, mode=01.
  - Required: no pulse ever appears.
  - Required: count_o=0.
- **Mode change in flight.** Generate a rise with mode=01, then set mode=00 on the next cycle.
  - Required: the queued pulse still appears.
  - Required: a later rise produces no pulse.
- **Saturation and clear (CNT_W=3).** Create 10 edges.
  - Required: count_o saturates at 7.
  - Pulse a clr_i in a cycle where a pulse occurs. Required: count_o=0 on the next cycle.
- **Reset mid-flight.** Assert rst in the cycle after a detection.
  - Required: y_o stays 0.
  - Required: count_o=0.
